mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester arbiter for one BRAM port with bounded bursts and
//            in-order read return through a READ_LAT-deep tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int                 c_cnt_w     = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
    localparam int                 c_last      = READ_LAT - 1;

    logic               r_owner;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic [READ_LAT-1:0] r_tag_v;
    logic [READ_LAT-1:0] r_tag_id;

    logic w_gnt_0;
    logic w_gnt_1;
    logic w_any_gnt;
    logic w_rd_issue;

    // Grants are gated by the reset input so outputs read zero while held in reset.
    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        if (rst) begin
            if (req_0 && req_1) begin
                if (r_burst_cnt < c_max_burst) begin
                    w_gnt_1 = r_owner;
                    w_gnt_0 = ~r_owner;
                end else begin
                    w_gnt_1 = ~r_owner;
                    w_gnt_0 = r_owner;
                end
            end else begin
                w_gnt_0 = req_0;
                w_gnt_1 = req_1;
            end
        end
    end

    assign w_any_gnt = w_gnt_0 | w_gnt_1;
    assign gnt_0     = w_gnt_0;
    assign gnt_1     = w_gnt_1;

    always_comb begin
        mem_en   = w_any_gnt;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_gnt_1) begin
            mem_we   = we_1;
            mem_addr = addr_1;
            mem_din  = wdata_1;
        end else if (w_gnt_0) begin
            mem_we   = we_0;
            mem_addr = addr_0;
            mem_din  = wdata_0;
        end
    end

    assign w_rd_issue = w_any_gnt & ~mem_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= 1'b0;
            r_burst_cnt <= '0;
        end else if (w_any_gnt) begin
            if (w_gnt_1 == r_owner) begin
                if (r_burst_cnt != c_max_burst) begin
                    r_burst_cnt <= r_burst_cnt + c_one;
                end
            end else begin
                r_owner     <= w_gnt_1;
                r_burst_cnt <= c_one;
            end
        end else begin
            r_burst_cnt <= '0;
        end
    end

    // Tag stage k holds the read granted k+1 cycles ago; the last stage lines up with mem_dout.
    generate
        if (READ_LAT == 1) begin : g_tag_lat1
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_tag_v  <= '0;
                    r_tag_id <= '0;
                end else begin
                    r_tag_v  <= w_rd_issue;
                    r_tag_id <= w_gnt_1;
                end
            end
        end else begin : g_tag_latn
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_tag_v  <= '0;
                    r_tag_id <= '0;
                end else begin
                    r_tag_v  <= {r_tag_v[READ_LAT-2:0], w_rd_issue};
                    r_tag_id <= {r_tag_id[READ_LAT-2:0], w_gnt_1};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            rvalid_0 <= r_tag_v[c_last] & ~r_tag_id[c_last];
            rvalid_1 <= r_tag_v[c_last] & r_tag_id[c_last];
            if (r_tag_v[c_last] && !r_tag_id[c_last]) begin
                rdata_0 <= mem_dout;
            end
            if (r_tag_v[c_last] && r_tag_id[c_last]) begin
                rdata_1 <= mem_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench; one arbiter with READ_LAT=1 (a_*) and one with
//            READ_LAT=2 (b_*) share the request inputs, each with its own BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic       req_0, req_1, we_0, we_1;
    logic [12:0] addr_0, addr_1;
    logic [7:0]  wdata_0, wdata_1;

    logic        a_gnt_0, a_gnt_1, a_rvalid_0, a_rvalid_1, a_mem_en, a_mem_we;
    logic [7:0]  a_rdata_0, a_rdata_1, a_mem_din, a_mem_dout;
    logic [12:0] a_mem_addr;
    logic        b_gnt_0, b_gnt_1, b_rvalid_0, b_rvalid_1, b_mem_en, b_mem_we;
    logic [7:0]  b_rdata_0, b_rdata_1, b_mem_din, b_mem_dout, b_dout_p;
    logic [12:0] b_mem_addr;

    logic [7:0]  mem_a [0:8191];
    logic [7:0]  mem_b [0:8191];

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .READ_LAT(1), .MAX_BURST(4)) u_dut_a (
        .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(a_gnt_0), .gnt_1(a_gnt_1), .rvalid_0(a_rvalid_0), .rvalid_1(a_rvalid_1),
        .rdata_0(a_rdata_0), .rdata_1(a_rdata_1), .mem_en(a_mem_en), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_dout(a_mem_dout)
    );

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .READ_LAT(2), .MAX_BURST(4)) u_dut_b (
        .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(b_gnt_0), .gnt_1(b_gnt_1), .rvalid_0(b_rvalid_0), .rvalid_1(b_rvalid_1),
        .rdata_0(b_rdata_0), .rdata_1(b_rdata_1), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first BRAMs with one and two cycles of output latency.
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr] <= a_mem_din;
            a_mem_dout <= a_mem_we ? a_mem_din : mem_a[a_mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr] <= b_mem_din;
            b_dout_p <= b_mem_we ? b_mem_din : mem_b[b_mem_addr];
        end
        b_mem_dout <= b_dout_p;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        req_0 = 1'b0;
        req_1 = 1'b0;
        we_0  = 1'b0;
        we_1  = 1'b0;
    endtask

    logic [8:0]  fair_seq;
    logic [12:0] pre_addr [4];
    logic [7:0]  pre_data [4];

    initial begin
        fair_seq = 9'b0_1111_0000;
        pre_addr = '{13'h010, 13'h001, 13'h002, 13'h003};
        pre_data = '{8'h5A, 8'hA1, 8'hA2, 8'hA3};

        rst = 1'b0;
        idle_all();
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        #2;
        req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b1;
        addr_0 = 13'h1FF; wdata_0 = 8'hFF; addr_1 = 13'h005; wdata_1 = 8'h77;

        @(negedge clk);
        check("rst_gnt_0", a_gnt_0, 0);
        check("rst_gnt_1", a_gnt_1, 0);
        check("rst_mem_en", a_mem_en, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_din", a_mem_din, 0);
        check("rst_rvalid_0", a_rvalid_0, 0);
        check("rst_rvalid_1", a_rvalid_1, 0);
        check("rst_rdata_0", a_rdata_0, 0);
        check("rst_rdata_1", a_rdata_1, 0);

        // Both ports write continuously starting with the first cycle out of reset.
        we_1 = 1'b1;
        addr_0 = 13'h1F0; wdata_0 = 8'h11;
        addr_1 = 13'h1F1; wdata_1 = 8'h22;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("fair_gnt_1[%0d]", i), a_gnt_1, fair_seq[i]);
            check($sformatf("fair_gnt_0[%0d]", i), a_gnt_0, !fair_seq[i]);
            if (i == 4) check("fair_mem_addr", a_mem_addr, 13'h1F1);
            next_cyc();
        end
        idle_all();
        next_cyc();

        for (int k = 0; k < 4; k++) begin
            req_0 = 1'b1; we_0 = 1'b1; addr_0 = pre_addr[k]; wdata_0 = pre_data[k];
            @(negedge clk);
            check($sformatf("pre_mem_we[%0d]", k), a_mem_we, 1);
            check($sformatf("pre_mem_din[%0d]", k), a_mem_din, pre_data[k]);
            next_cyc();
        end
        idle_all();
        next_cyc();

        // Port 1 takes two grants alone, one idle cycle, then both request.
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 13'h1F3; wdata_1 = 8'h33;
        next_cyc();
        next_cyc();
        idle_all();
        next_cyc();
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 13'h1F2; wdata_0 = 8'h44;
        req_1 = 1'b1; we_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("gap_gnt_1[%0d]", i), a_gnt_1, (i < 4) ? 1 : 0);
            next_cyc();
        end
        idle_all();
        next_cyc();

        // Single read on port 1.
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 13'h010;
        @(negedge clk);
        check("rd_gnt_1", a_gnt_1, 1);
        check("rd_gnt_0", a_gnt_0, 0);
        check("rd_mem_en", a_mem_en, 1);
        check("rd_mem_we", a_mem_we, 0);
        check("rd_mem_addr", a_mem_addr, 13'h010);
        next_cyc();
        idle_all();
        @(negedge clk);
        check("rd_a_rvalid_1_t1", a_rvalid_1, 0);
        next_cyc();
        @(negedge clk);
        check("rd_a_rvalid_1_t2", a_rvalid_1, 1);
        check("rd_a_rdata_1_t2", a_rdata_1, 8'h5A);
        check("rd_a_rdata_0_t2", a_rdata_0, 0);
        check("rd_b_rvalid_1_t2", b_rvalid_1, 0);
        next_cyc();
        @(negedge clk);
        check("rd_a_rvalid_1_t3", a_rvalid_1, 0);
        check("rd_b_rvalid_1_t3", b_rvalid_1, 1);
        check("rd_b_rdata_1_t3", b_rdata_1, 8'h5A);
        next_cyc();

        // Back-to-back reads 0x001 (p0), 0x002 (p1), 0x003 (p0).
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 13'h001;
        @(negedge clk);
        check("b2b_gnt_0_t0", a_gnt_0, 1);
        next_cyc();
        req_0 = 1'b0; req_1 = 1'b1; we_1 = 1'b0; addr_1 = 13'h002;
        @(negedge clk);
        check("b2b_gnt_1_t1", a_gnt_1, 1);
        next_cyc();
        req_1 = 1'b0; req_0 = 1'b1; addr_0 = 13'h003;
        @(negedge clk);
        check("b2b_a_rvalid_0_t2", a_rvalid_0, 1);
        check("b2b_a_rdata_0_t2", a_rdata_0, 8'hA1);
        next_cyc();
        idle_all();
        @(negedge clk);
        check("b2b_a_rvalid_1_t3", a_rvalid_1, 1);
        check("b2b_a_rdata_1_t3", a_rdata_1, 8'hA2);
        check("b2b_a_rdata_0_t3", a_rdata_0, 8'hA1);
        check("b2b_b_rvalid_0_t3", b_rvalid_0, 1);
        check("b2b_b_rdata_0_t3", b_rdata_0, 8'hA1);
        check("b2b_b_rdata_1_t3", b_rdata_1, 8'h5A);
        next_cyc();
        @(negedge clk);
        check("b2b_a_rvalid_0_t4", a_rvalid_0, 1);
        check("b2b_a_rdata_0_t4", a_rdata_0, 8'hA3);
        check("b2b_b_rvalid_1_t4", b_rvalid_1, 1);
        check("b2b_b_rdata_1_t4", b_rdata_1, 8'hA2);
        check("b2b_b_rvalid_0_t4", b_rvalid_0, 0);
        next_cyc();
        @(negedge clk);
        check("b2b_b_rvalid_0_t5", b_rvalid_0, 1);
        check("b2b_b_rdata_0_t5", b_rdata_0, 8'hA3);
        check("b2b_b_rdata_1_t5", b_rdata_1, 8'hA2);
        check("b2b_a_rvalid_0_t5", a_rvalid_0, 0);
        next_cyc();

        // Write 0x2B to 0x100 on port 0, then read it back on port 1.
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 13'h100; wdata_0 = 8'h2B;
        @(negedge clk);
        check("wr_mem_we", a_mem_we, 1);
        check("wr_mem_addr", a_mem_addr, 13'h100);
        check("wr_mem_din", a_mem_din, 8'h2B);
        next_cyc();
        req_0 = 1'b0; we_0 = 1'b0;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 13'h100;
        @(negedge clk);
        check("wr_rd_gnt_1", a_gnt_1, 1);
        next_cyc();
        idle_all();
        next_cyc();
        @(negedge clk);
        check("wr_rd_rvalid_1", a_rvalid_1, 1);
        check("wr_rd_rdata_1", a_rdata_1, 8'h2B);
        next_cyc();

        // Reset lands one cycle after a port 1 read is granted.
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 13'h002;
        @(negedge clk);
        check("mid_gnt_1", a_gnt_1, 1);
        next_cyc();
        rst = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 13'h001;
        @(negedge clk);
        check("mid_rst_gnt_0", a_gnt_0, 0);
        check("mid_rst_gnt_1", a_gnt_1, 0);
        check("mid_rst_mem_en", a_mem_en, 0);
        check("mid_rst_mem_addr", a_mem_addr, 0);
        check("mid_rst_a_rdata_1", a_rdata_1, 0);
        check("mid_rst_b_rdata_0", b_rdata_0, 0);
        check("mid_rst_a_rvalid_1", a_rvalid_1, 0);
        check("mid_rst_b_rvalid_1", b_rvalid_1, 0);
        next_cyc();
        @(negedge clk);
        check("mid_rst2_a_rvalid_1", a_rvalid_1, 0);
        check("mid_rst2_b_rvalid_1", b_rvalid_1, 0);
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_gnt_0", a_gnt_0, 1);
        check("post_rst_gnt_1", a_gnt_1, 0);
        next_cyc();
        idle_all();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_a_rvalid_1[%0d]", i), a_rvalid_1, 0);
            check($sformatf("post_rst_b_rvalid_1[%0d]", i), b_rvalid_1, 0);
            next_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
